uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that pairs with the existing UART transmitter. It recovers 8N1 frames from an asynchronous `rx` line using the shared baud generator's enable pulse at OVERSAMPLE× the bit rate, and checks each start and stop bit. Good bytes are queued in a small FIFO that the bus wrapper drains with a pop strobe. The block sits beside the transmitter in the peripheral's bus wrapper and runs entirely in the `wb_clk` domain.

## Interface
- `OVERSAMPLE`, default 16: `sample_en` pulses per bit; power of two, 8..32.
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `wb_clk` in, 1: system clock, rising edge.
- `wb_rst_n` in, 1: reset, asynchronous and active-low.
- `sample_en` in, 1: single-cycle enable at OVERSAMPLE×baud, from the baud generator with DIVIDE = f_clk/(baud·OVERSAMPLE).
- `rx` in, 1: asynchronous serial line; idles high.
- `re` in, 1: pop strobe; one entry per asserted cycle.
- `clr` in, 1: clears `overrun` and `frame_err`.
- `data` out, 8: FIFO head; 0 when empty.
- `ready` out, 1: FIFO is non-empty.
- `count` out, $clog2(DEPTH)+1: number of entries held.
- `overrun` out, 1: sticky; a good byte was dropped because the FIFO was full.
- `frame_err` out, 1: sticky; a stop bit was sampled low.

## Operation
- Reset values:
  - `data`=0, `ready`=0, `count`=0, `overrun`=0, `frame_err`=0.
  - Synchroniser flops = 1; state = IDLE; tick, bit counters and shift register = 0.
- `rx` passes through a 2-flop synchroniser to give `rx_s`. All FSM actions below happen only on cycles with `sample_en`=1.
- IDLE: if `rx_s`=0, go to START with tick=0.
- START: tick increments on each step. At tick=OVERSAMPLE/2−1 (mid start bit):
  - `rx_s`=1: treat as a glitch, return to IDLE with no flags set.
  - `rx_s`=0: go to DATA with tick=0, bit=0.
- DATA: at tick=OVERSAMPLE−1, `shift`<={`rx_s`,`shift[7:1]`} (LSB first), tick=0, bit++. After bit 7 is sampled, go to STOP.
- STOP: at tick=OVERSAMPLE−1, sample `rx_s`:
  - `rx_s`=1, FIFO not full: push `shift`; go to IDLE.
  - `rx_s`=1, FIFO full: drop the byte, set `overrun`; go to IDLE.
  - `rx_s`=0: discard the byte, set `frame_err`; go to BREAK.
- BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- FIFO:
  - Circular buffer; read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `re` when empty is ignored.
  - Push and pop in the same cycle: both execute and `count` is unchanged. This holds even when full, so no overrun occurs.
- Flags: `clr` zeroes both flags. If `clr` and a set event occur in the same cycle, the set wins.

## Timing
- `rx` to `rx_s`: 2 `wb_clk` cycles.
- The push is registered on the stop-sample cycle. `ready`, `data` and `count` update on the following edge.
- `re` at edge N: `data`, `ready` and `count` reflect the pop after edge N.
- Flags assert on the edge after the stop-bit sample.
- Back-to-back frames need no idle gap; a start bit is detected on the first `sample_en` after the return to IDLE.
- Tolerable baud mismatch is about ±4% at OVERSAMPLE=16. This is not checked in RTL.
- `wb_rst_n` low mid-frame forces the reset values immediately, with no clock needed. On release, the block resumes from IDLE.

## Test plan
All scenarios use OVERSAMPLE=16, DEPTH=4, `sample_en` every 4th clock, 8N1 stimulus.
- Send 0xA5 → `ready`=1, `data`=0xA5, `count`=1. Then `re` for 1 cycle → `ready`=0, `data`=0, `count`=0.
- Pull `rx` low for 4 `sample_en` pulses, then high → no push, flags 0. A following 0x5A is received correctly.
- Send 0x3C with the stop bit low, hold low for 2 bit times, then high → `frame_err`=1, `count`=0, no spurious bytes. Then 0x81 → `count`=1, `data`=0x81. Then `clr` → `frame_err`=0.
- Send 0x01..0x05 with no reads → `count`=4, `overrun`=1; pops return 0x01..0x04. Repeat with `re` pulsed on the 5th push cycle → `overrun` stays 0, `count` stays 4.
- Assert `wb_rst_n` low during data bit 3 → all outputs 0 immediately. After release, 0x55 is received correctly.
- Send 0x00 and 0xFF back-to-back with no gap → both are queued in order, flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO.
//   Recovers frames from the asynchronous rx line using an oversampling
//   enable from the shared baud generator. Start and stop bits are checked.
//   Good bytes are queued in a circular FIFO that is drained with a pop strobe.
// Ports:
//   wb_clk, wb_rst_n  - clock (rising edge), asynchronous active-low reset
//   sample_en         - single-cycle pulse at OVERSAMPLE x baud
//   rx                - asynchronous serial input, idles high
//   re                - pop strobe, one entry per asserted cycle
//   clr               - clears the sticky overrun/frame_err flags
//   data              - FIFO head, 0 when empty
//   ready             - FIFO non-empty
//   count             - number of entries held
//   overrun           - sticky: good byte dropped because the FIFO was full
//   frame_err         - sticky: stop bit sampled low
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  input  logic                     sample_en,
  input  logic                     rx,
  input  logic                     re,
  input  logic                     clr,
  output logic [7:0]               data,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     frame_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_sync1, r_sync2;
  logic          w_rx_s;
  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_push, w_set_ovr, w_set_ferr;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_full, w_pop;
  logic          r_overrun, r_frame_err;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx_s = r_sync2;

  assign w_pop  = re && (r_count != '0);
  assign w_full = (r_count == CNT_FULL);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_set_ovr   = 1'b0;
    w_set_ferr  = 1'b0;
    if (sample_en) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick == TICK_HALF) begin
            if (w_rx_s) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
        S_DATA: begin
          if (r_tick == TICK_LAST) begin
            w_shift_nxt = {w_rx_s, r_shift[7:1]};
            w_tick_nxt  = '0;
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
        S_STOP: begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt = '0;
            if (w_rx_s) begin
              // A pop in the same cycle frees a slot, so a full FIFO still accepts.
              if (!w_full || w_pop) w_push = 1'b1;
              else                  w_set_ovr = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_set_ferr  = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
        S_BREAK: begin
          if (w_rx_s) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_set_ovr)  r_overrun <= 1'b1;
      else if (clr)   r_overrun <= 1'b0;
      if (w_set_ferr) r_frame_err <= 1'b1;
      else if (clr)   r_frame_err <= 1'b0;
    end
  end

  assign data      = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign ready     = (r_count != '0);
  assign count     = r_count;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (OVERSAMPLE=16, DEPTH=4,
// sample_en every 4th clock, one bit = 64 clocks).
module tb_uart_rx;
  localparam int BIT_CLKS = 64;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n, sample_en, rx, re, clr;
  logic [7:0] data;
  logic       ready;
  logic [2:0] count;
  logic       overrun, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int q1;
  logic [7:0] exp_q[$];

  uart_rx #(.OVERSAMPLE(16), .DEPTH(4)) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .sample_en (sample_en),
    .rx        (rx),
    .re        (re),
    .clr       (clr),
    .data      (data),
    .ready     (ready),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 wb_clk = ~wb_clk;
  // cyc, read at a falling edge, is the index of the next rising edge.
  always @(posedge wb_clk) cyc <= cyc + 1;

  initial begin
    sample_en = 1'b0;
    forever begin
      @(negedge wb_clk);
      sample_en = (cyc % 4 == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every pop that the DUT accepts is compared with the scoreboard.
  initial begin
    forever begin
      @(negedge wb_clk);
      #3;
      if (re === 1'b1) begin
        if (ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got 0x%0h expected no byte", data);
          end else begin
            chk("pop_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
          end
        end else if (exp_q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL pop_missing: got ready=%b expected byte 0x%0h", ready, exp_q[0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic align();
    while (cyc % 4 != 2) @(negedge wb_clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge wb_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_push);
    align();
    if (expect_push) exp_q.push_back(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic pop();
    re = 1'b1;
    @(negedge wb_clk);
    re = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge wb_clk);
    clr = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge wb_clk);
  endtask

  initial begin
    rx = 1'b1; re = 1'b0; clr = 1'b0; wb_rst_n = 1'b0;
    repeat (3) @(negedge wb_clk);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 0);
    chk("rst_data", data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    wb_rst_n = 1'b1;
    repeat (8) @(negedge wb_clk);

    // Single byte, then pop.
    send_frame(8'hA5, 1'b1, 1'b1);
    settle();
    chk("a5_ready", ready, 1);
    chk("a5_data", data, 8'hA5);
    chk("a5_count", count, 1);
    pop();
    chk("a5_pop_ready", ready, 0);
    chk("a5_pop_data", data, 0);
    chk("a5_pop_count", count, 0);

    // Short low glitch is rejected.
    align();
    rx = 1'b0;
    repeat (16) @(negedge wb_clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge wb_clk);
    chk("glitch_count", count, 0);
    chk("glitch_ferr", frame_err, 0);
    chk("glitch_ovr", overrun, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    settle();
    chk("5a_count", count, 1);
    chk("5a_data", data, 8'h5A);
    pop();

    // Framing error with line held low (break).
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge wb_clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge wb_clk);
    chk("ferr_set", frame_err, 1);
    chk("ferr_count", count, 0);
    chk("ferr_ovr", overrun, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    settle();
    chk("81_count", count, 1);
    chk("81_data", data, 8'h81);
    pop();
    pulse_clr();
    chk("ferr_clr", frame_err, 0);

    // Overrun: five bytes into a four-entry FIFO.
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, b < 5);
    settle();
    chk("ovr_count", count, 4);
    chk("ovr_set", overrun, 1);
    repeat (4) pop();
    chk("ovr_drained", count, 0);
    pulse_clr();
    chk("ovr_clr", overrun, 0);

    // Pop coincident with the fifth push: frame 5 starts 4*640 clocks after
    // frame 1 and its stop sample lands 610 clocks into the frame.
    align();
    q1 = cyc;
    fork
      begin
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b1);
      end
      begin
        while (cyc != q1 + 4 * 640 + 610) @(negedge wb_clk);
        re = 1'b1;
        @(negedge wb_clk);
        re = 1'b0;
      end
    join
    settle();
    chk("pp_count", count, 4);
    chk("pp_ovr", overrun, 0);
    repeat (4) pop();
    chk("pp_drained", count, 0);

    // Reset during data bit 3.
    send_frame(8'h77, 1'b1, 1'b1);
    settle();
    chk("pre_rst_count", count, 1);
    align();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge wb_clk);
    wb_rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_ferr", frame_err, 0);
    exp_q.delete();
    rx = 1'b1;
    @(negedge wb_clk);
    repeat (4) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    repeat (8) @(negedge wb_clk);
    send_frame(8'h55, 1'b1, 1'b1);
    settle();
    chk("55_count", count, 1);
    chk("55_data", data, 8'h55);
    pop();

    // Back-to-back frames.
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    settle();
    chk("b2b_count", count, 2);
    chk("b2b_ovr", overrun, 0);
    chk("b2b_ferr", frame_err, 0);
    pop();
    pop();
    chk("b2b_drained", count, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
